seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Parametrised successor to the team's two-digit combinational hex-to-seven-segment display block.
- Latches an N-nibble hex value on a load strobe and time-multiplexes it onto one shared segment bus, driving a one-hot digit enable.
- Inserts a one-cycle anti-ghosting blank at every digit change.
- Sits between datapath status registers and the board's multiplexed display pins.

Parameters:
- NUM_DIGITS, 4, number of hex digits scanned; range 2..8.
- SCAN_DIV, 1000, clocks per digit slot; must be >= 2.
- CNT_W, $clog2(SCAN_DIV), width of the slot counter (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  when high at a clock edge, capture value/dp_in into the shadow registers.
- value  in  4*NUM_DIGITS  hex nibbles; nibble 0 = least significant = digit 0.
- dp_in  in  NUM_DIGITS  per-digit decimal point request.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-high, registered.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable, registered; all-zero during blank.
- frame_tick  out  1  one-cycle pulse at the start of each full scan frame.

Behaviour:
- Reset (async assert, sync release):
  - shadow value/dp = 0, slot counter cnt = 0, digit index idx = 0.
  - seg = 8'h00, digit_sel = 0, frame_tick = 0.
- Load:
  - shadow <= value, dp_shadow <= dp_in at the edge where load = 1.
  - Takes effect on the outputs one clock later, including mid-slot.
  - load held high recaptures every cycle; the last capture wins.
- Slot counter:
  - cnt increments every clock.
  - At cnt == SCAN_DIV-1: cnt <= 0 and idx <= idx+1.
  - idx wraps NUM_DIGITS-1 -> 0.
- Outputs, registered from the current cnt/idx/shadow, so one clock of latency:
  - cnt == 0 (blank cycle): digit_sel = 0, seg = 8'h00.
  - cnt != 0: digit_sel = 1<<idx; seg = {dp_shadow[idx], decode(shadow nibble idx)}.
  - frame_tick = 1 for exactly the cycle following cnt == 0 with idx == 0, i.e. coincident with digit 0's blank output. It is 0 otherwise, including the first post-reset frame.
- Decode table (g..a), 0..F: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
- Each digit is visible for SCAN_DIV-1 of SCAN_DIV clocks. Frame length = NUM_DIGITS*SCAN_DIV clocks.
- Reset mid-scan: all state and outputs return to reset values immediately; scan restarts at digit 0 after release. The shadow is lost and displays 0 until the next load.
- No handshake back-pressure: load is always accepted.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant nonzero shadow nibble show seg = 8'h00, including dp, while digit_sel still pulses normally.
  - Digit 0 is never blanked; all-zero shows a single "0".
  - Evaluated from the shadow, so it follows load with the same one-clock latency.
- Undefined: all digits are always displayed, zeros included.

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK = 8'h00.
  - Constant array SEG_HEX[0:15] of 7-bit codes.
  - Index order of segment bits.
- One sub-module: hex7seg_decode. Combinational, 4-bit nibble in, 7-bit segments out, using seg_pkg. It is instantiated once on the muxed nibble, not per digit.

Test Plan:
1. Reset, then run 2*SCAN_DIV+1 clocks with NUM_DIGITS=2, SCAN_DIV=4. Required after release:
   - Cycle 1: digit_sel=00, seg=00, frame_tick=1.
   - Cycles 2-4: digit_sel=01, seg=8'h3F.
   - Cycle 5: digit_sel=00 (blank).
   - Cycles 6-8: digit_sel=10, seg=8'h3F.
2. load with value=8'hF5, dp_in=2'b00 -> digit 0 slot shows seg=8'b01101101, digit 1 slot shows seg=8'b01110001.
3. load value=8'hA3, dp_in=2'b10 mid-slot of digit 1 -> next clock seg=8'hF7 (dp set, "A"). Digit 0 then shows 8'h4F.
4. frame_tick check over 3 frames -> exactly one pulse per NUM_DIGITS*SCAN_DIV clocks, aligned with digit 0's blank cycle.
5. Assert rst_n low while digit 1 is lit -> seg=0 and digit_sel=0 immediately (asynchronously, no clock edge needed). After release the scan restarts at digit 0 showing 8'h3F.
6. With SEG_LEADING_ZERO_BLANK_EN and NUM_DIGITS=4, load 16'h0070:
   - Digits 3 and 2 show seg=00 with digit_sel pulsing.
   - Digit 1 shows 8'h07; digit 0 shows 8'h3F.
   - Load 16'h0000 -> only digit 0 shows 8'h3F.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the seven-segment display path.
//   SEG_BLANK : all segments and decimal point off.
//   SEG_HEX   : 7-bit {g,f,e,d,c,b,a} codes for hex digits 0..F.
//   SEG_A..SEG_DP : bit positions of each segment in the 8-bit segment bus.
// -----------------------------------------------------------------------------
package seg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   localparam logic [6:0] SEG_HEX [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/hex7seg_decode.sv
// -----------------------------------------------------------------------------
// hex7seg_decode
// Combinational hex nibble to seven-segment pattern decoder.
// Ports:
//   nibble : 4-bit hex value to display.
//   segs   : 7-bit active-high {g,f,e,d,c,b,a} pattern.
// -----------------------------------------------------------------------------
module hex7seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   assign segs = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Latches an N-nibble hex value on a load strobe and time-multiplexes it onto
// one shared segment bus with a one-hot digit enable. Each digit slot lasts
// SCAN_DIV clocks; the first clock of every slot is blanked to stop ghosting.
//
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant nonzero nibble show a
//   blank segment bus (dp included) while their digit enable still pulses.
//   Digit 0 is always shown.
//
// Ports:
//   clk        : system clock, rising edge.
//   rst_n      : asynchronous active-low reset.
//   load       : capture value/dp_in into the shadow registers.
//   value      : hex nibbles, nibble 0 = digit 0.
//   dp_in      : per-digit decimal point request.
//   seg        : registered {dp,g,f,e,d,c,b,a}, active-high.
//   digit_sel  : registered one-hot digit enable, zero during blank.
//   frame_tick : one-cycle pulse coincident with digit 0's blank cycle.
// -----------------------------------------------------------------------------
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter  int NUM_DIGITS = 4,
   parameter  int SCAN_DIV   = 1000,
   localparam int CNT_W      = $clog2(SCAN_DIV)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_tick
);

   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic [4*NUM_DIGITS-1:0] shadow;
   logic [NUM_DIGITS-1:0]   dp_shadow;
   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;

   logic [3:0]              nibble;
   logic                    dp_bit;
   logic [6:0]              segs;
   logic                    show;

   logic [7:0]              seg_next;
   logic [NUM_DIGITS-1:0]   sel_next;
   logic                    tick_next;

   // Shadow capture and scan position.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow    <= '0;
         dp_shadow <= '0;
         cnt       <= '0;
         idx       <= '0;
      end else begin
         if (load) begin
            shadow    <= value;
            dp_shadow <= dp_in;
         end
         if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Single decoder on the currently selected digit.
   assign nibble = shadow[4*int'(idx) +: 4];
   assign dp_bit = dp_shadow[idx];

   hex7seg_decode u_decode (
      .nibble (nibble),
      .segs   (segs)
   );

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [IDX_W-1:0] msd;

   // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 shows.
   // NOTE: every combinational output gets a default before any branch so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      msd = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (shadow[4*i +: 4] != 4'h0) msd = IDX_W'(i);
      end
   end

   assign show = (idx <= msd);
`else
   assign show = 1'b1;
`endif

   always_comb begin
      seg_next  = SEG_BLANK;
      sel_next  = '0;
      tick_next = (cnt == '0) && (idx == '0);
      if (cnt != '0) begin
         sel_next = NUM_DIGITS'(1) << idx;
         if (show) seg_next = {dp_bit, segs};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= SEG_BLANK;
         digit_sel  <= '0;
         frame_tick <= 1'b0;
      end else begin
         seg        <= seg_next;
         digit_sel  <= sel_next;
         frame_tick <= tick_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver (NUM_DIGITS=4, SCAN_DIV=4).
// A reference model computes the expected outputs from the number of clock
// edges since reset and the last captured shadow; a compare process checks
// every negative clock edge. Directed sections pin literal expectations.
// Honours SEG_LEADING_ZERO_BLANK_EN when the build defines it.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int ND    = 4;
   localparam int SD    = 4;
   localparam int FRAME = ND * SD;
   localparam int OW    = 8 + ND + 1;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          load  = 1'b0;
   logic [4*ND-1:0] value = '0;
   logic [ND-1:0] dp_in = '0;
   logic [7:0]    seg;
   logic [ND-1:0] digit_sel;
   logic          frame_tick;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .NUM_DIGITS (ND),
      .SCAN_DIV   (SD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .value      (value),
      .dp_in      (dp_in),
      .seg        (seg),
      .digit_sel  (digit_sel),
      .frame_tick (frame_tick)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Output registered at an edge, given p edges already elapsed since reset.
   function automatic logic [OW-1:0] model_out(input int p, input logic [4*ND-1:0] v,
                                                input logic [ND-1:0] dp);
      int slot_pos = p % SD;
      int d        = (p / SD) % ND;
      logic [7:0]    s   = 8'h00;
      logic [ND-1:0] sel = '0;
      logic          tk  = (slot_pos == 0) && (d == 0);
      int            top = 0;
      for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'h0) top = i;
      if (slot_pos != 0) begin
         sel = ND'(1) << d;
         s   = {dp[d], hex_tab[v[4*d +: 4]]};
`ifdef SEG_LEADING_ZERO_BLANK_EN
         if (d > top) s = 8'h00;
`endif
      end
      return {s, sel, tk};
   endfunction

   int              m_pos = 0;
   logic [4*ND-1:0] m_val = '0;
   logic [ND-1:0]   m_dp  = '0;
   logic [OW-1:0]   exp_vec = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos   <= 0;
         m_val   <= '0;
         m_dp    <= '0;
         exp_vec <= '0;
      end else begin
         exp_vec <= model_out(m_pos, m_val, m_dp);
         m_pos   <= m_pos + 1;
         if (load) begin
            m_val <= value;
            m_dp  <= dp_in;
         end
      end
   end

   always @(negedge clk) check("scan", 32'({seg, digit_sel, frame_tick}), 32'(exp_vec));

   // ---------------- directed + random stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] outv(input logic [7:0] s, input logic [ND-1:0] sel,
                                        input logic tk);
      return 32'({s, sel, tk});
   endfunction

   logic [31:0] dut_v;
   assign dut_v = 32'({seg, digit_sel, frame_tick});

`ifdef SEG_LEADING_ZERO_BLANK_EN
   localparam logic [7:0] LZ_SEG = 8'h00;
`else
   localparam logic [7:0] LZ_SEG = 8'h3F;
`endif

   initial begin
      int k;
      int n_pulse;
      logic [15:0] tmp;

      // Test 1: reset state and first two slots.
      tick(3);
      check("reset_state", dut_v, outv(8'h00, 4'b0000, 1'b0));
      rst_n = 1'b1;
      tick(1);
      check("t1_c1", dut_v, outv(8'h00, 4'b0000, 1'b1));
      for (int c = 2; c <= 4; c++) begin
         tick(1);
         check("t1_d0", dut_v, outv(8'h3F, 4'b0001, 1'b0));
      end
      tick(1);
      check("t1_c5", dut_v, outv(8'h00, 4'b0000, 1'b0));
      for (int c = 6; c <= 8; c++) begin
         tick(1);
         check("t1_d1", dut_v, outv(8'h3F, 4'b0010, 1'b0));
      end

      // Test 2: load 0xF5 at edge 10.
      tick(1);                                   // k = 9
      load = 1'b1; value = 16'h00F5; dp_in = 4'b0000;
      tick(1);                                   // k = 10
      load = 1'b0;
      tick(8);                                   // k = 18
      check("t2_d0", dut_v, outv(8'h6D, 4'b0001, 1'b0));
      tick(4);                                   // k = 22
      check("t2_d1", dut_v, outv(8'h71, 4'b0010, 1'b0));

      // Test 3: mid-slot load, one clock of latency.
      load = 1'b1; value = 16'h00A3; dp_in = 4'b0010;
      tick(1);                                   // k = 23
      load = 1'b0;
      check("t3_old", dut_v, outv(8'h71, 4'b0010, 1'b0));
      tick(1);                                   // k = 24
      check("t3_new", dut_v, outv(8'hF7, 4'b0010, 1'b0));
      tick(10);                                  // k = 34
      check("t3_d0", dut_v, outv(8'h4F, 4'b0001, 1'b0));

      // Test 4: exactly one frame_tick per frame over three frames.
      k = 34;
      n_pulse = 0;
      for (int c = 0; c < 3 * FRAME; c++) begin
         tick(1);
         k++;
         if (frame_tick) begin
            n_pulse++;
            check("t4_align", 32'((k - 1) % FRAME), 32'd0);
            check("t4_blank", 32'(digit_sel), 32'd0);
         end
      end
      check("t4_count", 32'(n_pulse), 32'd3);

      // Test 5: async reset while digit 1 is lit.
      tick(4);                                   // k = 86
      check("t5_lit", dut_v, outv(8'hF7, 4'b0010, 1'b0));
      #2 rst_n = 1'b0;
      #1 check("t5_async", dut_v, outv(8'h00, 4'b0000, 1'b0));
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("t5_c1", dut_v, outv(8'h00, 4'b0000, 1'b1));
      tick(1);                                   // k = 2
      check("t5_d0", dut_v, outv(8'h3F, 4'b0001, 1'b0));

      // Test 6: leading-zero behaviour on 0x0070 and 0x0000.
      load = 1'b1; value = 16'h0070; dp_in = 4'b0000;
      tick(1);                                   // k = 3
      load = 1'b0;
      tick(16);                                  // k = 19
      check("t6_d0", dut_v, outv(8'h3F, 4'b0001, 1'b0));
      tick(4);
      check("t6_d1", dut_v, outv(8'h07, 4'b0010, 1'b0));
      tick(4);
      check("t6_d2", dut_v, outv(LZ_SEG, 4'b0100, 1'b0));
      tick(4);                                   // k = 31
      check("t6_d3", dut_v, outv(LZ_SEG, 4'b1000, 1'b0));
      load = 1'b1; value = 16'h0000;
      tick(1);                                   // k = 32
      load = 1'b0;
      tick(3);                                   // k = 35
      check("t6_z_d0", dut_v, outv(8'h3F, 4'b0001, 1'b0));
      tick(4);                                   // k = 39
      check("t6_z_d1", dut_v, outv(LZ_SEG, 4'b0010, 1'b0));

      // Random phase: loads with varied leading zeros, occasional async reset.
      for (int c = 0; c < 3000; c++) begin
         tick(1);
         load  = ($urandom_range(0, 5) == 0);
         tmp   = 16'($urandom);
         value = tmp >> (4 * $urandom_range(0, 4));
         dp_in = ND'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
      end
      load = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
